cva6_hpicache_fetch_arbiter: RTL and testbench
==============================================

// Module: cva6_hpicache_fetch_arbiter
// PURPOSE
//  Multi-requester fetch front-end for the HPDcache-based I$. Arbitrates NumPorts fetch
//  requesters (frontend, prefetcher, debug) round-robin onto the single cache request port.
//  Tags each request with its port index, routes responses back by that tag, and drops
//  responses for killed fetches. Sequences flush (drain, cache flush, ack). Counts misses.
// PARAMETERS
//  NumPorts        2   number of fetch requesters (1..8)
//  AddrWidth       56  fetch physical address width
//  FetchWidth      64  response data width
//  MaxOutstanding  4   max in-flight requests per port (power of 2, >=2)
//  CntWidth        32  miss counter width
// PORTS
//  clk_i             in   1                    clock
//  rst_i             in   1                    async reset, active-high
//  req_valid_i       in   NumPorts             per-port fetch request valid
//  req_ready_o       out  NumPorts             per-port grant (handshake = valid & ready)
//  req_addr_i        in   NumPorts*AddrWidth   per-port address, port p at [p*AddrWidth +: AddrWidth]
//  req_kill_i        in   NumPorts             discard all in-flight responses of port p
//  rsp_valid_o       out  NumPorts             one-hot response valid
//  rsp_data_o        out  FetchWidth           response data (shared)
//  rsp_error_o       out  1                    response carries bus/access error
//  cache_req_valid_o out  1                    request to cache
//  cache_req_ready_i in   1                    cache accepts
//  cache_req_addr_o  out  AddrWidth            granted address
//  cache_req_tid_o   out  max(1,$clog2(NumPorts)) granted port index
//  cache_rsp_valid_i in   1                    cache response valid (no backpressure)
//  cache_rsp_tid_i   in   max(1,$clog2(NumPorts)) response port index
//  cache_rsp_data_i  in   FetchWidth           response data
//  cache_rsp_error_i in   1                    response error
//  cache_flush_o     out  1                    flush request to cache, held until ack
//  cache_flush_ack_i in   1                    cache flush done (1-cycle pulse)
//  flush_i           in   1                    flush request from controller (pulse)
//  flush_ack_o       out  1                    flush complete (1-cycle pulse)
//  miss_i            in   1                    cache read-miss event pulse
//  miss_clr_i        in   1                    clear miss counter
//  miss_count_o      out  CntWidth             saturating miss count
// BEHAVIOUR
//  - Reset: all outputs 0; RR pointer=0; outstanding/drop counters 0; FSM=IDLE; count=0.
//  - Arbitration (IDLE only): candidate = valid port with outstanding<MaxOutstanding, first at or
//    after RR pointer. cache_req_valid_o=1 combinationally; req_ready_o[p]=cache_req_ready_i for
//    the winner only. On handshake: outstanding[p]++, RR pointer = p+1 (mod NumPorts). Winner
//    held stable while cache_req_ready_i=0 (no re-arbitration until accepted).
//  - Response: cache_rsp_valid_i with tid p -> outstanding[p]--. If drop[p]>0: drop[p]--,
//    rsp_valid_o stays 0. Else rsp_valid_o[p]=1 same cycle (zero latency, combinational),
//    data/error passed through. tid>=NumPorts: ignored, no counter change.
//  - Kill: req_kill_i[p] sets drop[p] = outstanding[p] after this cycle's updates (a response
//    for p in the kill cycle is dropped; a grant to p in the kill cycle is NOT dropped).
//  - Downstream contract: responses in order per port; at most one response per cycle.
//  - Flush FSM: IDLE --flush_i--> DRAIN (no grants) --all outstanding==0--> FLUSH
//    (cache_flush_o=1) --cache_flush_ack_i--> ACK (flush_ack_o=1 one cycle) --> IDLE.
//    flush_i in DRAIN/FLUSH/ACK ignored (merged). flush_i while idle with nothing outstanding:
//    DRAIN lasts exactly 1 cycle. A request handshaking in the flush_i cycle completes normally.
//  - Miss counter: +1 per miss_i, saturates at all-ones; miss_clr_i wins over simultaneous miss_i.
//  - Counter widths $clog2(MaxOutstanding)+1; outstanding never exceeds MaxOutstanding, never
//    underflows (assertion: response with outstanding==0 is an error).
//  - Async reset mid-flush or with requests in flight returns to reset state; stale cache
//    responses after reset are the integrator's responsibility (cache reset together).
// TESTING
//  - NumPorts=2, both valid every cycle, ready=1 -> grants alternate 0,1,0,1; tids match.
//  - Port0 valid, ready=0 for 3 cycles -> addr/tid stable, port1 raised mid-stall not granted.
//  - Port0 issues 4 (MaxOutstanding), no responses -> 5th blocked, ready[0]=0; 1 rsp -> regrant.
//  - Port1 has 3 in flight, kill pulse -> next 3 tid=1 responses invisible, 4th delivered.
//  - flush_i with 2 outstanding -> cache_flush_o only after both responses; ack 1 cycle after
//    cache_flush_ack_i; no grants between flush_i and flush_ack_o.
//  - miss_i at count=all-ones -> holds; miss_i+miss_clr_i same cycle -> count=0.

Source files
------------

// File: rtl/cva6_hpicache_fetch_arbiter_if.sv
// Fetch-side and cache-side handshake bundle of the I$ fetch arbiter.
// The master modport is the arbiter's view; slave is the requester/cache environment.
interface cva6_hpicache_fetch_arbiter_if #(
    parameter int unsigned NumPorts   = 2,
    parameter int unsigned AddrWidth  = 56,
    parameter int unsigned FetchWidth = 64,
    parameter int unsigned TidWidth   = (NumPorts > 1) ? $clog2(NumPorts) : 1
);
    logic [NumPorts-1:0]           req_valid;
    logic [NumPorts-1:0]           req_ready;
    logic [NumPorts*AddrWidth-1:0] req_addr;
    logic [NumPorts-1:0]           req_kill;
    logic [NumPorts-1:0]           rsp_valid;
    logic [FetchWidth-1:0]         rsp_data;
    logic                          rsp_error;
    logic                          cache_req_valid;
    logic                          cache_req_ready;
    logic [AddrWidth-1:0]          cache_req_addr;
    logic [TidWidth-1:0]           cache_req_tid;
    logic                          cache_rsp_valid;
    logic [TidWidth-1:0]           cache_rsp_tid;
    logic [FetchWidth-1:0]         cache_rsp_data;
    logic                          cache_rsp_error;

    modport master (
        input  req_valid, req_addr, req_kill, cache_req_ready,
        input  cache_rsp_valid, cache_rsp_tid, cache_rsp_data, cache_rsp_error,
        output req_ready, rsp_valid, rsp_data, rsp_error,
        output cache_req_valid, cache_req_addr, cache_req_tid
    );

    modport slave (
        output req_valid, req_addr, req_kill, cache_req_ready,
        output cache_rsp_valid, cache_rsp_tid, cache_rsp_data, cache_rsp_error,
        input  req_ready, rsp_valid, rsp_data, rsp_error,
        input  cache_req_valid, cache_req_addr, cache_req_tid
    );
endinterface

// File: rtl/cva6_hpicache_fetch_arbiter.sv
// Round-robin fetch arbiter in front of the HPDcache I$: tags requests with the port index,
// routes tagged responses back, drops responses of killed fetches, sequences flush, counts misses.
module cva6_hpicache_fetch_arbiter #(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned AddrWidth      = 56,
    parameter int unsigned FetchWidth     = 64,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    cva6_hpicache_fetch_arbiter_if.master fetch_io,
    input  logic                flush_i,
    output logic                cache_flush_o,
    input  logic                cache_flush_ack_i,
    output logic                flush_ack_o,
    input  logic                miss_i,
    input  logic                miss_clr_i,
    output logic [CntWidth-1:0] miss_count_o
);
    localparam int unsigned TidWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1;
    localparam int unsigned OcntWidth = $clog2(MaxOutstanding) + 1;
    localparam logic [OcntWidth-1:0] OcntMax = OcntWidth'(MaxOutstanding);

    typedef enum logic [1:0] {StIdle, StDrain, StFlush, StAck} state_e;

    state_e                state_q, state_d;
    logic [TidWidth-1:0]   rr_q, rr_d, lock_idx_q, winner;
    logic                  lock_q, lock_d, found, grant, req_valid, all_idle, rsp_underflow;
    logic [NumPorts-1:0]   eligible, req_ready, rsp_sel, rsp_valid;
    logic [AddrWidth-1:0]  addr_arr [NumPorts];
    logic [OcntWidth-1:0]  outstanding_q [NumPorts];
    logic [OcntWidth-1:0]  outstanding_d [NumPorts];
    logic [OcntWidth-1:0]  drop_q [NumPorts];
    logic [OcntWidth-1:0]  drop_d [NumPorts];
    logic [CntWidth-1:0]   miss_count_q, miss_count_d;

    // A stalled winner stays locked so the cache sees a stable address/tid until it accepts.
    always_comb begin : arbitrate
        logic [TidWidth-1:0] cand;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            eligible[p] = fetch_io.req_valid[p] && (outstanding_q[p] < OcntMax);
            addr_arr[p] = fetch_io.req_addr[p*AddrWidth +: AddrWidth];
        end
        if (lock_q) begin
            found  = fetch_io.req_valid[lock_idx_q];
            winner = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                cand = TidWidth'((32'(rr_q) + i) % NumPorts);
                if (!found && eligible[cand]) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        req_valid = (state_q == StIdle) && found;
        if (req_valid) req_ready[winner] = fetch_io.cache_req_ready;
        grant  = req_valid && fetch_io.cache_req_ready;
        lock_d = req_valid && !fetch_io.cache_req_ready;
        rr_d   = rr_q;
        if (grant) rr_d = (32'(winner) == NumPorts - 1) ? '0 : winner + TidWidth'(1);
    end

    assign fetch_io.req_ready       = req_ready;
    assign fetch_io.cache_req_valid = req_valid;
    assign fetch_io.cache_req_addr  = req_valid ? addr_arr[winner] : '0;
    assign fetch_io.cache_req_tid   = req_valid ? winner : '0;

    // Kill snapshots the pre-grant count: a grant in the kill cycle belongs to the new stream.
    always_comb begin
        all_idle      = 1'b1;
        rsp_underflow = 1'b0;
        for (int unsigned p = 0; p < NumPorts; p++) begin
            rsp_sel[p] = fetch_io.cache_rsp_valid && (32'(fetch_io.cache_rsp_tid) < NumPorts)
                         && (fetch_io.cache_rsp_tid == TidWidth'(p));
            rsp_valid[p] = rsp_sel[p] && (drop_q[p] == '0) && !fetch_io.req_kill[p];
            outstanding_d[p] = outstanding_q[p]
                             + OcntWidth'(grant && (winner == TidWidth'(p)))
                             - OcntWidth'(rsp_sel[p]);
            drop_d[p] = drop_q[p];
            if (rsp_sel[p] && (drop_q[p] != '0)) drop_d[p] = drop_q[p] - OcntWidth'(1);
            if (fetch_io.req_kill[p]) drop_d[p] = outstanding_q[p] - OcntWidth'(rsp_sel[p]);
            if (outstanding_q[p] != '0) all_idle = 1'b0;
            if (rsp_sel[p] && (outstanding_q[p] == '0)) rsp_underflow = 1'b1;
        end
    end

    assign fetch_io.rsp_valid = rsp_valid;
    assign fetch_io.rsp_data  = (|rsp_valid) ? fetch_io.cache_rsp_data : '0;
    assign fetch_io.rsp_error = (|rsp_valid) && fetch_io.cache_rsp_error;

    always_comb begin
        state_d       = state_q;
        cache_flush_o = 1'b0;
        flush_ack_o   = 1'b0;
        unique case (state_q)
            StIdle:  if (flush_i) state_d = StDrain;
            StDrain: if (all_idle) state_d = StFlush;
            StFlush: begin
                cache_flush_o = 1'b1;
                if (cache_flush_ack_i) state_d = StAck;
            end
            StAck: begin
                flush_ack_o = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        miss_count_d = miss_count_q;
        if (miss_clr_i) miss_count_d = '0;
        else if (miss_i && !(&miss_count_q)) miss_count_d = miss_count_q + CntWidth'(1);
    end

    assign miss_count_o = miss_count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            rr_q         <= '0;
            lock_q       <= 1'b0;
            lock_idx_q   <= '0;
            miss_count_q <= '0;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                outstanding_q[p] <= '0;
                drop_q[p]        <= '0;
            end
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            lock_idx_q   <= winner;
            miss_count_q <= miss_count_d;
            for (int unsigned p = 0; p < NumPorts; p++) begin
                outstanding_q[p] <= outstanding_d[p];
                drop_q[p]        <= drop_d[p];
            end
        end
    end

    // A response for a port with nothing in flight means the cache broke the tag contract.
    assert property (@(posedge clk_i) disable iff (rst_i) !rsp_underflow);
endmodule

// File: tb/tb_cva6_hpicache_fetch_arbiter.sv
// Directed bench for cva6_hpicache_fetch_arbiter: 2 ports, 4 in flight, 4-bit miss counter.
module tb_cva6_hpicache_fetch_arbiter;
    localparam logic [55:0] A0 = 56'h00_1000_0000_0040;
    localparam logic [55:0] A1 = 56'h00_2000_0000_0080;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush, cache_flush, cache_flush_ack, flush_ack, miss, miss_clr;
    logic [3:0] miss_count;
    int         checks = 0;
    int         failures = 0;

    cva6_hpicache_fetch_arbiter_if #(.NumPorts(2), .AddrWidth(56), .FetchWidth(64)) bus ();

    cva6_hpicache_fetch_arbiter #(
        .NumPorts(2), .AddrWidth(56), .FetchWidth(64), .MaxOutstanding(4), .CntWidth(4)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .fetch_io         (bus),
        .flush_i          (flush),
        .cache_flush_o    (cache_flush),
        .cache_flush_ack_i(cache_flush_ack),
        .flush_ack_o      (flush_ack),
        .miss_i           (miss),
        .miss_clr_i       (miss_clr),
        .miss_count_o     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rsp(input logic tid, input logic [63:0] data, input logic err);
        bus.cache_rsp_valid = 1'b1;
        bus.cache_rsp_tid   = tid;
        bus.cache_rsp_data  = data;
        bus.cache_rsp_error = err;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.cache_req_valid !== 1'b0) begin failures++;
            $display("FAIL reset_cache_req_valid: got %b want 0", bus.cache_req_valid); end
        checks++; if (bus.req_ready !== 2'b00) begin failures++;
            $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 2'b00) begin failures++;
            $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
        checks++; if ({cache_flush, flush_ack} !== 2'b00) begin failures++;
            $display("FAIL reset_flush: got %b want 00", {cache_flush, flush_ack}); end
        checks++; if (miss_count !== 4'd0) begin failures++;
            $display("FAIL reset_miss_count: got %0d want 0", miss_count); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic exp_tid;
        exp_tid = 1'b0;
        bus.req_valid = 2'b11; bus.cache_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.cache_req_tid !== exp_tid) begin failures++;
                $display("FAIL alt_tid[%0d]: got %0d want %0d", i, bus.cache_req_tid, exp_tid); end
            checks++; if (bus.cache_req_addr !== (exp_tid ? A1 : A0)) begin failures++;
                $display("FAIL alt_addr[%0d]: got %h want %h", i, bus.cache_req_addr,
                         exp_tid ? A1 : A0); end
            checks++; if (bus.req_ready !== (exp_tid ? 2'b10 : 2'b01)) begin failures++;
                $display("FAIL alt_ready[%0d]: got %b", i, bus.req_ready); end
            tick();
            exp_tid = ~exp_tid;
        end
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_tid = (i % 2 == 1);
            drive_rsp(exp_tid, 64'hD000 + 64'(i), i == 3);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== (exp_tid ? 2'b10 : 2'b01)) begin failures++;
                $display("FAIL rsp_route[%0d]: got %b", i, bus.rsp_valid); end
            checks++; if ({bus.rsp_error, bus.rsp_data} !== {i == 3, 64'hD000 + 64'(i)}) begin
                failures++;
                $display("FAIL rsp_data[%0d]: got %b/%h want %b/%h", i, bus.rsp_error,
                         bus.rsp_data, i == 3, 64'hD000 + 64'(i)); end
            tick();
        end
        bus.cache_rsp_valid = 1'b0;
    endtask

    task automatic test_stall();
        bus.req_valid = 2'b01; bus.cache_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin failures++;
            $display("FAIL stall_pre_grant: got %b want 01", bus.req_ready); end
        tick();
        bus.cache_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) bus.req_valid = 2'b11;
            @(negedge clk);
            checks++; if ({bus.cache_req_valid, bus.cache_req_tid, bus.cache_req_addr,
                           bus.req_ready} !== {1'b1, 1'b0, A0, 2'b00}) begin failures++;
                $display("FAIL stall_hold[%0d]: got v=%b tid=%0d addr=%h rdy=%b", i,
                         bus.cache_req_valid, bus.cache_req_tid, bus.cache_req_addr,
                         bus.req_ready); end
            tick();
        end
        bus.cache_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin failures++;
            $display("FAIL stall_release: got %b want 01", bus.req_ready); end
        tick();
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b10) begin failures++;
            $display("FAIL stall_next_rr: got %b want 10", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            drive_rsp(i == 2, 64'hA0 + 64'(i), 1'b0);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== ((i == 2) ? 2'b10 : 2'b01)) begin failures++;
                $display("FAIL stall_rsp[%0d]: got %b", i, bus.rsp_valid); end
            tick();
        end
        bus.cache_rsp_valid = 1'b0;
    endtask

    task automatic test_max_outstanding();
        bus.req_valid = 2'b01; bus.cache_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (bus.req_ready !== 2'b01) begin failures++;
                $display("FAIL max_grant[%0d]: got %b want 01", i, bus.req_ready); end
            tick();
        end
        @(negedge clk);
        checks++; if ({bus.cache_req_valid, bus.req_ready} !== 3'b000) begin failures++;
            $display("FAIL max_block: got v=%b rdy=%b", bus.cache_req_valid, bus.req_ready); end
        tick();
        drive_rsp(1'b0, 64'hB0, 1'b0);
        @(negedge clk);
        checks++; if ({bus.rsp_valid, bus.cache_req_valid} !== 3'b010) begin failures++;
            $display("FAIL max_rsp: got rsp=%b v=%b", bus.rsp_valid, bus.cache_req_valid); end
        tick();
        bus.cache_rsp_valid = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin failures++;
            $display("FAIL max_regrant: got %b want 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            drive_rsp(1'b0, 64'hB1 + 64'(i), 1'b0);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 2'b01) begin failures++;
                $display("FAIL max_drain[%0d]: got %b want 01", i, bus.rsp_valid); end
            tick();
        end
        bus.cache_rsp_valid = 1'b0;
    endtask

    task automatic test_kill();
        bus.req_valid = 2'b10; bus.cache_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.req_kill = 2'b10;
            @(negedge clk);
            checks++; if (bus.req_ready !== 2'b10) begin failures++;
                $display("FAIL kill_grant[%0d]: got %b want 10", i, bus.req_ready); end
            tick();
        end
        bus.req_kill = 2'b00; bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            drive_rsp(1'b1, 64'hC0 + 64'(i), 1'b0);
            @(negedge clk);
            checks++; if (bus.rsp_valid !== ((i == 3) ? 2'b10 : 2'b00)) begin failures++;
                $display("FAIL kill_drop[%0d]: got %b", i, bus.rsp_valid); end
            if (i == 3) begin
                checks++; if (bus.rsp_data !== 64'hC3) begin failures++;
                    $display("FAIL kill_data: got %h want c3", bus.rsp_data); end
            end
            tick();
        end
        bus.cache_rsp_valid = 1'b0;
    endtask

    task automatic test_flush_drain();
        bus.req_valid = 2'b11; bus.cache_req_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b01) begin failures++;
            $display("FAIL fl_grant0: got %b want 01", bus.req_ready); end
        tick();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== 2'b10) begin failures++;
            $display("FAIL fl_grant_in_flush_cycle: got %b want 10", bus.req_ready); end
        tick();
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive_rsp(i == 1, 64'hE0 + 64'(i), 1'b0);
            else bus.cache_rsp_valid = 1'b0;
            @(negedge clk);
            checks++; if ({cache_flush, bus.cache_req_valid, bus.req_ready} !== 4'b0000) begin
                failures++;
                $display("FAIL fl_drain[%0d]: got flush=%b v=%b rdy=%b", i, cache_flush,
                         bus.cache_req_valid, bus.req_ready); end
            tick();
        end
        @(negedge clk);
        checks++; if ({cache_flush, bus.cache_req_valid} !== 2'b10) begin failures++;
            $display("FAIL fl_flush: got flush=%b v=%b", cache_flush, bus.cache_req_valid); end
        tick();
        cache_flush_ack = 1'b1;
        @(negedge clk);
        checks++; if ({cache_flush, flush_ack} !== 2'b10) begin failures++;
            $display("FAIL fl_ack_cycle: got %b want 10", {cache_flush, flush_ack}); end
        tick();
        cache_flush_ack = 1'b0;
        @(negedge clk);
        checks++; if ({cache_flush, flush_ack, bus.cache_req_valid} !== 3'b010) begin
            failures++;
            $display("FAIL fl_ack_out: got %b want 010",
                     {cache_flush, flush_ack, bus.cache_req_valid}); end
        tick();
        @(negedge clk);
        checks++; if ({flush_ack, bus.req_ready} !== 3'b001) begin failures++;
            $display("FAIL fl_resume: got ack=%b rdy=%b", flush_ack, bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        drive_rsp(1'b0, 64'hE2, 1'b0);
        tick();
        bus.cache_rsp_valid = 1'b0;
    endtask

    task automatic test_flush_idle();
        flush = 1'b1;
        @(negedge clk);
        tick();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (cache_flush !== 1'b0) begin failures++;
            $display("FAIL fi_drain: got %b want 0", cache_flush); end
        tick();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (cache_flush !== 1'b1) begin failures++;
            $display("FAIL fi_flush: got %b want 1", cache_flush); end
        tick();
        flush = 1'b0; cache_flush_ack = 1'b1;
        tick();
        cache_flush_ack = 1'b0;
        @(negedge clk);
        checks++; if (flush_ack !== 1'b1) begin failures++;
            $display("FAIL fi_ack: got %b want 1", flush_ack); end
        tick();
        @(negedge clk);
        checks++; if ({cache_flush, flush_ack} !== 2'b00) begin failures++;
            $display("FAIL fi_merged: got %b want 00", {cache_flush, flush_ack}); end
    endtask

    task automatic test_miss();
        miss = 1'b1;
        repeat (3) tick();
        miss = 1'b0;
        @(negedge clk);
        checks++; if (miss_count !== 4'd3) begin failures++;
            $display("FAIL miss_count3: got %0d want 3", miss_count); end
        miss_clr = 1'b1;
        tick();
        miss_clr = 1'b0;
        @(negedge clk);
        checks++; if (miss_count !== 4'd0) begin failures++;
            $display("FAIL miss_clr: got %0d want 0", miss_count); end
        miss = 1'b1;
        repeat (15) tick();
        @(negedge clk);
        checks++; if (miss_count !== 4'd15) begin failures++;
            $display("FAIL miss_full: got %0d want 15", miss_count); end
        tick();
        @(negedge clk);
        checks++; if (miss_count !== 4'd15) begin failures++;
            $display("FAIL miss_saturate: got %0d want 15", miss_count); end
        miss_clr = 1'b1;
        tick();
        miss = 1'b0; miss_clr = 1'b0;
        @(negedge clk);
        checks++; if (miss_count !== 4'd0) begin failures++;
            $display("FAIL miss_clr_wins: got %0d want 0", miss_count); end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0; cache_flush_ack = 1'b0; miss = 1'b0; miss_clr = 1'b0;
        bus.req_valid = 2'b00; bus.req_kill = 2'b00; bus.req_addr = {A1, A0};
        bus.cache_req_ready = 1'b0;
        bus.cache_rsp_valid = 1'b0; bus.cache_rsp_tid = 1'b0;
        bus.cache_rsp_data = '0; bus.cache_rsp_error = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_max_outstanding();
        test_kill();
        test_flush_drain();
        test_flush_idle();
        test_miss();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
